// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N:1 valid/ready stream mux, fixed-select or round-robin, registered output
module stream_mux_rr #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic [N_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  rr_en,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic             load_ok;
    logic             fix_found;
    logic             rr_found;
    logic [SEL_W-1:0] rr_grant;
    logic [SEL_W-1:0] rr_idx;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic             xfer;

    assign load_ok   = !out_valid_q || out_ready;
    assign fix_found = (int'(sel) < N_IN) && in_valid[sel];

    // First valid channel at or after rr_ptr, wrapping modulo N_IN.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        rr_idx   = '0;
        for (int k = 0; k < N_IN; k++) begin
            rr_idx = SEL_W'((int'(rr_ptr_q) + k) % N_IN);
            if (!rr_found && in_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_grant = rr_idx;
            end
        end
    end

    always_comb begin
        grant_valid = rr_en ? rr_found : fix_found;
        grant       = rr_en ? rr_grant : sel;
        xfer        = grant_valid && load_ok && !reset;
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant*WIDTH +: WIDTH];
            out_sel_d   = grant;
            if (rr_en) begin
                rr_ptr_d = (int'(grant) == N_IN - 1) ? '0 : grant + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed vector bench for stream_mux_rr
module tb_stream_mux_rr;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic [1:0]   sel;
    logic         rr_en;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(32), .N_IN(4), .SEL_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sel       (sel),
        .rr_en     (rr_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    typedef struct {
        logic         rst;
        logic [3:0]   iv;
        logic [1:0]   sel;
        logic         rr;
        logic         ordy;
        logic [127:0] data;
        logic [3:0]   e_rdy;
        logic         e_ov;
        logic [31:0]  e_od;
        logic [1:0]   e_os;
    } vec_t;

    vec_t vecs[$];

    localparam logic [127:0] D  = {32'h000000D3, 32'hCAFEF00D, 32'h000000B1, 32'h000000A0};
    localparam logic [127:0] BP = {32'h0, 32'h0, 32'h00000022, 32'h00000011};

    task automatic add(input logic rst, input logic [3:0] iv, input logic [1:0] s, input logic rr,
                       input logic ordy, input logic [127:0] data, input logic [3:0] e_rdy,
                       input logic e_ov, input logic [31:0] e_od, input logic [1:0] e_os);
        vec_t v;
        v.rst = rst; v.iv = iv; v.sel = s; v.rr = rr; v.ordy = ordy; v.data = data;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset     = v.rst;
        in_valid  = v.iv;
        sel       = v.sel;
        rr_en     = v.rr;
        out_ready = v.ordy;
        in_data   = v.data;
        #1;
        chk("in_ready", idx, {28'h0, in_ready}, {28'h0, v.e_rdy});
        chk("in_ready_onehot", idx, {31'h0, ($countones(in_ready) <= 1)}, 32'h1);
        @(posedge clk);
        #1;
        chk("out_valid", idx, {31'h0, out_valid}, {31'h0, v.e_ov});
        chk("out_data", idx, out_data, v.e_od);
        chk("out_sel", idx, {30'h0, out_sel}, {30'h0, v.e_os});
    endtask

    initial begin
        reset = 1'b1; in_valid = '0; sel = '0; rr_en = 1'b0; out_ready = 1'b1; in_data = '0;

        // reset held with all channels valid
        add(1, 4'b1111, 0, 0, 1, D, 4'b0000, 0, 32'h0, 0);
        add(1, 4'b1111, 0, 0, 1, D, 4'b0000, 0, 32'h0, 0);
        // fixed mode
        add(0, 4'b1111, 2, 0, 1, D, 4'b0100, 1, 32'hCAFEF00D, 2);
        add(0, 4'b1101, 1, 0, 1, D, 4'b0000, 0, 32'hCAFEF00D, 2);
        add(0, 4'b1101, 1, 0, 1, D, 4'b0000, 0, 32'hCAFEF00D, 2);
        add(0, 4'b1000, 3, 0, 1, D, 4'b1000, 1, 32'h000000D3, 3);
        // round-robin, all valid, two full rotations
        for (int r = 0; r < 2; r++) begin
            add(0, 4'b1111, 0, 1, 1, D, 4'b0001, 1, 32'h000000A0, 0);
            add(0, 4'b1111, 0, 1, 1, D, 4'b0010, 1, 32'h000000B1, 1);
            add(0, 4'b1111, 0, 1, 1, D, 4'b0100, 1, 32'hCAFEF00D, 2);
            add(0, 4'b1111, 0, 1, 1, D, 4'b1000, 1, 32'h000000D3, 3);
        end
        // round-robin, channels 0 and 3 only
        for (int r = 0; r < 2; r++) begin
            add(0, 4'b1001, 0, 1, 1, D, 4'b0001, 1, 32'h000000A0, 0);
            add(0, 4'b1001, 0, 1, 1, D, 4'b1000, 1, 32'h000000D3, 3);
        end
        // pointer moves to 3, survives a fixed-mode transfer
        add(0, 4'b0100, 0, 1, 1, D, 4'b0100, 1, 32'hCAFEF00D, 2);
        add(0, 4'b1111, 1, 0, 1, D, 4'b0010, 1, 32'h000000B1, 1);
        add(0, 4'b1111, 0, 1, 1, D, 4'b1000, 1, 32'h000000D3, 3);
        add(0, 4'b0000, 0, 1, 1, D, 4'b0000, 0, 32'h000000D3, 3);
        // backpressure then simultaneous drain + load
        add(0, 4'b0001, 0, 0, 1, BP, 4'b0001, 1, 32'h00000011, 0);
        for (int r = 0; r < 3; r++)
            add(0, 4'b0010, 1, 0, 0, BP, 4'b0000, 1, 32'h00000011, 0);
        add(0, 4'b0010, 1, 0, 1, BP, 4'b0010, 1, 32'h00000022, 1);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // reset while a word is stalled in the output register
        begin
            vec_t v;
            v.rst = 1; v.iv = 4'b1111; v.sel = 1; v.rr = 1; v.ordy = 0; v.data = D;
            v.e_rdy = 4'b0000; v.e_ov = 0; v.e_od = 32'h0; v.e_os = 0;
            apply(v, 100);
            v.rst = 0; v.iv = 4'b0110; v.e_rdy = 4'b0010; v.e_ov = 1; v.e_od = 32'h000000B1; v.e_os = 1;
            apply(v, 101);
            v.iv = 4'b0110; v.e_rdy = 4'b0000;
            apply(v, 102);
            v.ordy = 1; v.e_rdy = 4'b0100; v.e_od = 32'hCAFEF00D; v.e_os = 2;
            apply(v, 103);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
